// File: rtl/wb_spram_bridge.sv
// rtl/wb_spram_bridge.sv - Wishbone classic slave front-end for a single-port RAM
// Full-word writes go straight through; partial byte-lane writes use read-modify-write.
module wb_spram_bridge #(
    parameter int unsigned size       = 'h1000,
    parameter int unsigned addr_width = $clog2(size),
    parameter int unsigned data_width = 16,
    parameter int unsigned sel_width  = data_width / 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [addr_width-1:0] adr_i,
    input  logic [data_width-1:0] dat_i,
    input  logic [sel_width-1:0]  sel_i,
    output logic [data_width-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [addr_width-1:0] ram_address,
    output logic [data_width-1:0] ram_data,
    input  logic [data_width-1:0] ram_q,
    output logic                  ram_wren,
    output logic                  ram_cen
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] RMW  = 3'd2;
    localparam logic [2:0] ACK  = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    // One extra bit so a power-of-two depth is representable for the range check.
    localparam logic [addr_width:0] size_l = (addr_width + 1)'(size);

    logic [2:0]            state;
    logic [addr_width-1:0] adr_q;
    logic [data_width-1:0] dat_q;
    logic [sel_width-1:0]  sel_q;
    logic [data_width-1:0] merged;

    logic req, in_range, sel_full, sel_none;

    // Gating with reset_n keeps the strobes quiet while reset is held.
    assign req      = cyc_i & stb_i & reset_n;
    assign in_range = {1'b0, adr_i} < size_l;
    assign sel_full = &sel_i;
    assign sel_none = ~|sel_i;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        adr_q <= adr_i;
                        dat_q <= dat_i;
                        sel_q <= sel_i;
                        if (!in_range)
                            state <= ERR;
                        else if (!we_i)
                            state <= RD;
                        else if (sel_full || sel_none)
                            state <= ACK;
                        else
                            state <= RMW;
                    end
                end
                RMW:     state <= cyc_i ? ACK : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-lane merge of the latched write data over the word fetched in IDLE.
    always_comb begin
        merged = ram_q;
        for (int i = 0; i < int'(sel_width); i++) begin
            if (sel_q[i])
                merged[8*i +: 8] = dat_q[8*i +: 8];
        end
    end

    always_comb begin
        dat_o       = '0;
        ack_o       = 1'b0;
        err_o       = 1'b0;
        ram_address = adr_q;
        ram_data    = '0;
        ram_wren    = 1'b0;
        ram_cen     = 1'b0;
        case (state)
            IDLE: begin
                ram_address = adr_i;
                if (req && in_range) begin
                    if (!we_i) begin
                        ram_cen = 1'b1;
                    end else if (sel_full) begin
                        ram_cen  = 1'b1;
                        ram_wren = 1'b1;
                        ram_data = dat_i;
                    end else if (!sel_none) begin
                        ram_cen = 1'b1;
                    end
                end
            end
            RD: begin
                ack_o = 1'b1;
                dat_o = ram_q;
            end
            RMW: begin
                if (cyc_i) begin
                    ram_cen  = 1'b1;
                    ram_wren = 1'b1;
                    ram_data = merged;
                end
            end
            ACK:     ack_o = 1'b1;
            ERR:     err_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_spram_bridge.sv
// tb/tb_wb_spram_bridge.sv - self-checking bench for wb_spram_bridge
module tb_wb_spram_bridge;

    localparam int SIZE = 3000;
    localparam int AW   = 12;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [15:0]   dat_in = '0;
    logic [1:0]    sel = '0;
    logic [15:0]   dat_o, ram_data;
    logic [15:0]   ram_q = '0;
    logic          ack_o, err_o, ram_wren, ram_cen;
    logic [AW-1:0] ram_address;

    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];

    int n_cmp = 0;
    int n_bad = 0;

    wb_spram_bridge #(.size(SIZE), .addr_width(AW), .data_width(16), .sel_width(2)) dut (
        .clock(clock), .reset_n(reset_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat_in), .sel_i(sel), .dat_o(dat_o), .ack_o(ack_o),
        .err_o(err_o), .ram_address(ram_address), .ram_data(ram_data), .ram_q(ram_q),
        .ram_wren(ram_wren), .ram_cen(ram_cen)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_cen) begin
            if (ram_wren) mem[ram_address] <= ram_data;
            ram_q <= mem[ram_address];
        end
    end

    function automatic logic [15:0] lane_merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] s);
        logic [15:0] mask;
        mask = {{8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    // Single bus transfer: reports strobes at accept, latency (0 = timeout), response kind and data.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] s,
                        output int lat, output bit got_ack, output bit got_err, output logic [15:0] rdata,
                        output logic cen0, output logic wren0, output bit bad);
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_in = d; sel = s;
        #1;
        cen0 = ram_cen; wren0 = ram_wren;
        lat = 0; got_ack = 0; got_err = 0; rdata = '0; bad = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (ack_o && err_o) bad = 1;
            if (!ack_o && dat_o != 16'h0) bad = 1;
            if (ack_o || err_o) begin
                lat = k; got_ack = ack_o; got_err = err_o; rdata = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clock);
        if (ack_o || err_o) bad = 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        cyc = 1'b1; stb = 1'b1; adr = 12'd5;
        #1;
        n_cmp++;
        if ({ack_o, err_o, ram_cen, ram_wren} !== 4'b0000 || dat_o !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: ack=%b err=%b cen=%b wren=%b dat=%h, required all 0", ack_o, err_o, ram_cen, ram_wren, dat_o);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_rmw();
        int lat; bit ga, ge, bad; logic [15:0] rd; logic c0, w0;
        mem[20] = 16'h5678; ref_mem[20] = 16'h5678;
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'd20; dat_in = 16'hFFFF; sel = 2'b01;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ack_o !== 1'b0 || ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_rmw_strobes: ack=%b wren=%b, required 0 0", ack_o, ram_wren);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (mem[20] !== 16'h5678 || ack_o || err_o) begin
            n_bad++;
            $display("FAIL reset_mid_rmw_ram: ram=%h ack=%b err=%b, required 5678 0 0", mem[20], ack_o, err_o);
        end
        xfer(1'b0, 12'd20, 16'h0, 2'b11, lat, ga, ge, rd, c0, w0, bad);
        n_cmp++;
        if (lat != 1 || !ga || rd !== 16'h5678) begin
            n_bad++;
            $display("FAIL reset_mid_rmw_idle: lat=%0d ack=%b data=%h, required 1 1 5678", lat, ga, rd);
        end
    endtask

    task automatic test_full_write_read();
        int lat; bit ga, ge, bad; logic [15:0] rd; logic c0, w0;
        xfer(1'b1, 12'd5, 16'hA55A, 2'b11, lat, ga, ge, rd, c0, w0, bad);
        ref_mem[5] = 16'hA55A;
        n_cmp++;
        if (!c0 || !w0 || lat != 1 || !ga || ge || bad) begin
            n_bad++;
            $display("FAIL full_write: cen=%b wren=%b lat=%0d ack=%b err=%b bad=%b, required 1 1 1 1 0 0", c0, w0, lat, ga, ge, bad);
        end
        xfer(1'b0, 12'd5, 16'h0, 2'b00, lat, ga, ge, rd, c0, w0, bad);
        n_cmp++;
        if (!c0 || w0 || lat != 1 || !ga || rd !== 16'hA55A || bad) begin
            n_bad++;
            $display("FAIL full_read: cen=%b wren=%b lat=%0d ack=%b data=%h, required 1 0 1 1 a55a", c0, w0, lat, ga, rd);
        end
    endtask

    task automatic test_partial_write();
        int lat; bit ga, ge, bad; logic [15:0] rd; logic c0, w0;
        mem[7] = 16'h1234; ref_mem[7] = 16'h1234;
        xfer(1'b1, 12'd7, 16'hABCD, 2'b01, lat, ga, ge, rd, c0, w0, bad);
        ref_mem[7] = 16'h12CD;
        n_cmp++;
        if (!c0 || w0 || lat != 2 || !ga || bad) begin
            n_bad++;
            $display("FAIL partial_write: cen=%b wren=%b lat=%0d ack=%b bad=%b, required 1 0 2 1 0", c0, w0, lat, ga, bad);
        end
        xfer(1'b0, 12'd7, 16'h0, 2'b11, lat, ga, ge, rd, c0, w0, bad);
        n_cmp++;
        if (lat != 1 || !ga || rd !== 16'h12CD) begin
            n_bad++;
            $display("FAIL partial_read: lat=%0d ack=%b data=%h, required 1 1 12cd", lat, ga, rd);
        end
    endtask

    task automatic test_abort();
        bit seen;
        mem[9] = 16'h1234; ref_mem[9] = 16'h1234;
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'd9; dat_in = 16'hABCD; sel = 2'b10;
        @(negedge clock);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        #1;
        n_cmp++;
        if (ram_wren !== 1'b0 || ack_o !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_strobes: wren=%b ack=%b, required 0 0", ram_wren, ack_o);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (ack_o || err_o) seen = 1;
        end
        n_cmp++;
        if (seen || mem[9] !== 16'h1234) begin
            n_bad++;
            $display("FAIL abort_result: late_ack=%b ram=%h, required 0 1234", seen, mem[9]);
        end
    endtask

    task automatic test_error();
        int lat; bit ga, ge, bad; logic [15:0] rd; logic c0, w0;
        xfer(1'b0, 12'd3000, 16'h0, 2'b11, lat, ga, ge, rd, c0, w0, bad);
        n_cmp++;
        if (c0 || ga || !ge || lat != 1 || bad) begin
            n_bad++;
            $display("FAIL err_read_3000: cen=%b ack=%b err=%b lat=%0d bad=%b, required 0 0 1 1 0", c0, ga, ge, lat, bad);
        end
        xfer(1'b1, 12'd4095, 16'h5555, 2'b11, lat, ga, ge, rd, c0, w0, bad);
        n_cmp++;
        if (c0 || w0 || ga || !ge || lat != 1 || bad) begin
            n_bad++;
            $display("FAIL err_write_4095: cen=%b wren=%b ack=%b err=%b lat=%0d, required 0 0 0 1 1", c0, w0, ga, ge, lat);
        end
        xfer(1'b0, 12'd2999, 16'h0, 2'b11, lat, ga, ge, rd, c0, w0, bad);
        n_cmp++;
        if (!ga || ge || lat != 1 || rd !== ref_mem[2999]) begin
            n_bad++;
            $display("FAIL last_word_read: ack=%b err=%b lat=%0d data=%h, required 1 0 1 %h", ga, ge, lat, rd, ref_mem[2999]);
        end
    endtask

    task automatic test_back_to_back();
        int idx, acks;
        bit exp_ack;
        idx = 0; acks = 0;
        @(negedge clock);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'd0; sel = 2'b11;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clock);
            exp_ack = (n % 2 == 1) && (n <= 7);
            n_cmp++;
            if (ack_o !== exp_ack) begin
                n_bad++;
                $display("FAIL b2b_ack_slot%0d: ack=%b, required %b", n, ack_o, exp_ack);
            end
            if (ack_o) begin
                acks++;
                n_cmp++;
                if (dat_o !== ref_mem[idx]) begin
                    n_bad++;
                    $display("FAIL b2b_data%0d: dat=%h, required %h", idx, dat_o, ref_mem[idx]);
                end
                idx++;
                if (idx < 4) adr = AW'(idx);
                else begin cyc = 1'b0; stb = 1'b0; end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        n_cmp++;
        if (acks != 4) begin
            n_bad++;
            $display("FAIL b2b_ack_count: acks=%0d, required 4", acks);
        end
    endtask

    task automatic test_random();
        int lat, exp_lat, diffs;
        bit ga, ge, bad, exp_err;
        logic [15:0] rd, d;
        logic c0, w0, exp_cen, exp_wren;
        logic [AW-1:0] a;
        logic [1:0] s;
        logic w;
        for (int t = 0; t < 80; t++) begin
            a = AW'($urandom_range(0, 3099));
            if (t % 4 == 0) a = AW'($urandom_range(0, 7));
            d = 16'($urandom);
            s = 2'($urandom);
            w = 1'($urandom);
            exp_err  = (int'(a) >= SIZE);
            exp_cen  = !exp_err && !(w && s == 2'b00);
            exp_wren = !exp_err && w && s == 2'b11;
            exp_lat  = (!exp_err && w && (s == 2'b01 || s == 2'b10)) ? 2 : 1;
            xfer(w, a, d, s, lat, ga, ge, rd, c0, w0, bad);
            n_cmp++;
            if (ge !== exp_err || ga !== !exp_err || lat != exp_lat || c0 !== exp_cen || w0 !== exp_wren || bad) begin
                n_bad++;
                $display("FAIL rand%0d_ctrl: we=%b adr=%0d sel=%b err=%b ack=%b lat=%0d cen=%b wren=%b bad=%b, required err=%b lat=%0d cen=%b wren=%b",
                         t, w, a, s, ge, ga, lat, c0, w0, bad, exp_err, exp_lat, exp_cen, exp_wren);
            end
            if (!exp_err && !w) begin
                n_cmp++;
                if (rd !== ref_mem[a]) begin
                    n_bad++;
                    $display("FAIL rand%0d_data: adr=%0d dat=%h, required %h", t, a, rd, ref_mem[a]);
                end
            end
            if (!exp_err && w) ref_mem[a] = lane_merge(ref_mem[a], d, s);
        end
        diffs = 0;
        for (int i = 0; i < SIZE; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        n_cmp++;
        if (diffs != 0) begin
            n_bad++;
            $display("FAIL ram_contents: %0d words differ, required 0", diffs);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_abort();
        test_error();
        test_back_to_back();
        test_reset_mid_rmw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
